grey_incr_sched: RTL and testbench

GREY_INCR_SCHED -- requirements
Module: grey_incr_sched

---
 rtl/grey_incr_sched.sv | 85 ++++++++
 tb/tb_grey_incr_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/grey_incr_sched.sv
// grey_incr_sched: arbitrates requesters and a periodic tick onto one shared 6-bit Gray counter,
// granting one increment at a time followed by GAP cool-down cycles.
module grey_incr_sched #(
   parameter int NREQ = 4,
   parameter int GAP  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            div_en,
   input  logic [3:0]      div_val,
   output logic [NREQ-1:0] ack,
   output logic            incr,
   output logic [2:0]      grant_id,
   output logic [5:0]      grey,
   output logic            busy,
   output logic            overrun
);
   typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;
   state_t state, nxt;
   logic [1:0] last_ptr, rr_idx, cand;
   logic [2:0] cool_cnt;
   logic [3:0] div_cnt;
   logic       tick_pend, tick_gen, tick_clr, grant;
   logic [5:0] bin_nxt, grey_nxt;

   function automatic logic [5:0] g2b(input logic [5:0] g);
      logic [5:0] b;
      b[5] = g[5];
      for (int i = 4; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
      return b;
   endfunction

   assign bin_nxt  = g2b(grey) + 6'd1;
   assign grey_nxt = bin_nxt ^ (bin_nxt >> 1);
   assign grant    = (state == IDLE) && (tick_pend || (|req));
   assign tick_gen = div_en && (div_cnt == div_val);
   assign tick_clr = grant && tick_pend;

   // Later writes win, so the candidate just after last_ptr ends up with top priority.
   always_comb begin
      rr_idx = 2'd0;
      cand = 2'd0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = last_ptr + 2'(k);
         if (req[cand]) rr_idx = cand;
      end
   end

   always_comb begin
      nxt = (state == IDLE) ? (grant ? GRANT : IDLE) :
            (state == GRANT) ? ((GAP == 0) ? IDLE : COOL) :
            (cool_cnt == 3'd0) ? IDLE : COOL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_ptr  <= 2'd3;
         cool_cnt  <= 3'd0;
         div_cnt   <= 4'd0;
         tick_pend <= 1'b0;
         ack       <= '0;
         incr      <= 1'b0;
         grant_id  <= 3'd0;
         grey      <= 6'd0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= nxt;
         incr      <= grant;
         ack       <= (grant && !tick_pend) ? ({{(NREQ-1){1'b0}}, 1'b1} << rr_idx) : '0;
         busy      <= (nxt != IDLE);
         cool_cnt  <= (state == GRANT) ? 3'(GAP - 1) : cool_cnt - 3'd1;
         div_cnt   <= (!div_en || tick_gen) ? 4'd0 : div_cnt + 4'd1;
         tick_pend <= tick_gen || (tick_pend && !tick_clr);
         overrun   <= overrun || (tick_gen && tick_pend && !tick_clr);
         if (grant) begin
            grant_id <= tick_pend ? 3'd4 : {1'b0, rr_idx};
            grey     <= grey_nxt;
            if (!tick_pend) last_ptr <= rr_idx;
         end
      end
   end
endmodule

// File: tb/tb_grey_incr_sched.sv
// tb_grey_incr_sched: three DUTs (GAP 0, 2, 7) on shared random stimulus, each checked every cycle
// against a countdown/integer-counter model of the scheduler.
module tb_grey_incr_sched;
   typedef struct {
      int cnt; int left; int last; int div;
      bit tp; bit ovr; logic [3:0] ack; bit incr; int gid;
   } mst_t;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] req;
   logic div_en;
   logic [3:0] div_val;
   logic [3:0] ack_w [3];
   logic incr_w [3];
   logic [2:0] gid_w [3];
   logic [5:0] grey_w [3];
   logic busy_w [3];
   logic ovr_w [3];
   logic [5:0] prev_grey [3];
   logic [5:0] gseq [8] = '{6'd1, 6'd3, 6'd2, 6'd6, 6'd7, 6'd5, 6'd4, 6'd12};
   mst_t m [3];
   int checks = 0;
   int failures = 0;
   logic pin_en = 1'b0;
   int pin_i = 0;
   logic [15:0] pin_v = '0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      grey_incr_sched #(.NREQ(4), .GAP(g == 0 ? 0 : g == 1 ? 2 : 7)) u (
         .clk(clk), .rst(rst), .req(req), .div_en(div_en), .div_val(div_val),
         .ack(ack_w[g]), .incr(incr_w[g]), .grant_id(gid_w[g]), .grey(grey_w[g]),
         .busy(busy_w[g]), .overrun(ovr_w[g]));
   end

   function automatic int gap_of(input int i);
      return i == 0 ? 0 : i == 1 ? 2 : 7;
   endfunction

   function automatic logic [15:0] pk(input logic [3:0] a, input logic i, input logic [2:0] g,
                                      input logic [5:0] gr, input logic b, input logic o);
      return {a, i, g, gr, b, o};
   endfunction

   function automatic mst_t m_rst();
      mst_t s;
      s.cnt = 0; s.left = 0; s.last = 3; s.div = 0; s.tp = 0; s.ovr = 0;
      s.ack = 4'd0; s.incr = 0; s.gid = 0;
      return s;
   endfunction

   function automatic logic [15:0] mpk(input mst_t s);
      logic [5:0] c;
      c = 6'(s.cnt);
      return pk(s.ack, s.incr, 3'(s.gid), c ^ (c >> 1), s.left > 0, s.ovr);
   endfunction

   // left = busy cycles still to run (grant plus cool-down); cnt = binary increment count
   function automatic mst_t mdl_next(input mst_t s, input logic [3:0] r, input logic den,
                                     input logic [3:0] dv, input int gap);
      mst_t n;
      bit gen, clr, found;
      int w;
      n = s;
      gen = den && (s.div == int'(dv));
      n.div = (!den || gen) ? 0 : (s.div + 1) % 16;
      n.incr = 0;
      n.ack = 4'd0;
      clr = 0;
      if (s.left > 0) n.left = s.left - 1;
      else if (s.tp || r != 4'd0) begin
         n.incr = 1;
         n.left = gap + 1;
         n.cnt = (s.cnt + 1) % 64;
         if (s.tp) begin
            clr = 1;
            n.gid = 4;
         end else begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               w = (s.last + k) % 4;
               if (!found && r[w]) begin
                  found = 1;
                  n.gid = w;
                  n.last = w;
                  n.ack = 4'(1 << w);
               end
            end
         end
      end
      n.tp = gen || (s.tp && !clr);
      n.ovr = s.ovr || (gen && s.tp && !clr);
      return n;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) m[i] = m_rst();
      forever begin
         @(posedge clk or negedge rst);
         for (int i = 0; i < 3; i++)
            m[i] = !rst ? m_rst() : mdl_next(m[i], req, div_en, div_val, gap_of(i));
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) prev_grey[i] = 6'd0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("outs%0d", i),
                {ack_w[i], incr_w[i], gid_w[i], grey_w[i], busy_w[i], ovr_w[i]}, mpk(m[i]));
            if (rst && incr_w[i])
               chk($sformatf("gray_step%0d", i), 16'($countones(grey_w[i] ^ prev_grey[i])), 16'd1);
            prev_grey[i] = grey_w[i];
         end
         if (pin_en) chk($sformatf("pin%0d", pin_i), mpk(m[pin_i]), pin_v);
      end
   end

   task automatic tk(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic pin(input int i, input logic [15:0] v);
      pin_i = i;
      pin_v = v;
      pin_en = 1'b1;
      @(negedge clk);
      #2;
      pin_en = 1'b0;
   endtask

   task automatic rst_pulse();
      rst = 1'b0;
      tk(2);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; req = 4'd0; div_en = 1'b0; div_val = 4'd0;
      tk(2);
      pin(1, pk(4'd0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));
      rst = 1'b1;
      req = 4'b0100;
      pin(1, pk(4'b0100, 1'b1, 3'd2, 6'd1, 1'b1, 1'b0));
      req = 4'd0;
      pin(1, pk(4'd0, 1'b0, 3'd2, 6'd1, 1'b1, 1'b0));
      pin(1, pk(4'd0, 1'b0, 3'd2, 6'd1, 1'b1, 1'b0));
      pin(1, pk(4'd0, 1'b0, 3'd2, 6'd1, 1'b0, 1'b0));
      tk(10);
      req = 4'hF;
      rst_pulse();
      for (int k = 0; k < 8; k++) begin
         pin(0, pk(4'(1 << (k % 4)), 1'b1, 3'(k % 4), gseq[k], 1'b1, 1'b0));
         tk(1);
      end
      req = 4'd0; div_en = 1'b1; div_val = 4'd0;
      rst_pulse();
      pin(2, pk(4'd0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));
      pin(2, pk(4'd0, 1'b1, 3'd4, 6'd1, 1'b1, 1'b0));
      pin(2, pk(4'd0, 1'b0, 3'd4, 6'd1, 1'b1, 1'b1));
      tk(4);
      pin(2, pk(4'd0, 1'b0, 3'd4, 6'd1, 1'b1, 1'b1));
      div_en = 1'b0;
      tk(12);
      div_val = 4'd3; div_en = 1'b1; req = 4'b0001;
      rst_pulse();
      pin(1, pk(4'b0001, 1'b1, 3'd0, 6'd1, 1'b1, 1'b0));
      tk(3);
      pin(1, pk(4'd0, 1'b1, 3'd4, 6'd3, 1'b1, 1'b0));
      tk(3);
      pin(1, pk(4'd0, 1'b1, 3'd4, 6'd2, 1'b1, 1'b0));
      div_en = 1'b0; req = 4'b0001;
      rst_pulse();
      for (int k = 1; k <= 64; k++) begin
         if (k == 63) pin(0, pk(4'b0001, 1'b1, 3'd0, 6'b100000, 1'b1, 1'b0));
         else if (k == 64) pin(0, pk(4'b0001, 1'b1, 3'd0, 6'd0, 1'b1, 1'b0));
         else tk(1);
         tk(1);
      end
      req = 4'd0;
      tk(10);
      req = 4'hF;
      @(posedge clk);
      #2;
      rst = 1'b0;
      pin(1, pk(4'd0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));
      rst = 1'b1;
      req = 4'b1010;
      pin(1, pk(4'b0010, 1'b1, 3'd1, 6'd1, 1'b1, 1'b0));
      req = 4'd0;
      tk(5);
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) begin
            div_en = 1'b0;
            tk(1);
            div_val = 4'($urandom_range(0, 15));
            div_en = 1'($urandom_range(0, 1));
         end
         if (c % 700 == 350) begin
            @(posedge clk);
            #3;
            rst = 1'b0;
            @(negedge clk);
            #2;
            rst = 1'b1;
         end
         if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
         tk(1);
      end
      tk(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
